vector_list_writer: RTL

// Double-buffered display-list RAM. It is the write-side counterpart of the vector display's list reader.
// - Write side: accepts draw commands over a valid/ready handshake and packs them into vector words in the back bank.
// - Read side: serves the vector display through the same addr -> data_out combinational port the display uses for ROM.
// - On the display's frame_drawn pulse, the freshly sealed back bank becomes the front bank.
// - Instantiated beside top_vector_display in place of the static ROM; runs on the display clock (clk4MHz).

---
 rtl/vector_list_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vector_list_writer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_list_writer
//  Description : Double-buffered display-list RAM. Packs draw commands into
//                the back bank and serves the front bank to the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_list_writer #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OUT_WIDTH-1:0]    cmd_x,
    input  logic [OUT_WIDTH-1:0]    cmd_y,
    input  logic                    cmd_draw,
    input  logic                    cmd_last,
    input  logic [ADDRESSWIDTH-1:0] addr,
    output logic [DATAWIDTH-1:0]    data_out,
    input  logic                    frame_drawn,
    output logic                    swap_done,
    output logic                    overflow,
    output logic [ADDRESSWIDTH-1:0] level
);

    localparam int                      c_WORDS     = 2 * (2 ** ADDRESSWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] c_LAST_SLOT = '1;
    localparam logic [DATAWIDTH-1:0]    c_EOF_WORD  = {1'b1, {(DATAWIDTH-1){1'b0}}};

    localparam logic [1:0] c_FILL      = 2'd0;
    localparam logic [1:0] c_SEAL      = 2'd1;
    localparam logic [1:0] c_WAIT_SWAP = 2'd2;
    localparam logic [1:0] c_SWAP      = 2'd3;

    logic [DATAWIDTH-1:0]    r_ram [0:c_WORDS-1];
    logic [1:0]              r_state;
    logic [ADDRESSWIDTH-1:0] r_wptr;
    logic                    r_front;
    logic                    r_front_valid;
    logic                    r_overflow;
    logic                    r_swap_done;
    logic                    r_cmd_ready;

    logic [1:0]              w_state_nxt;
    logic [ADDRESSWIDTH-1:0] w_wptr_nxt;
    logic                    w_we;
    logic [DATAWIDTH-1:0]    w_wdata;
    logic                    w_ovf_set;
    logic                    w_hs;
    logic                    w_has_room;
    logic [DATAWIDTH-1:0]    w_cmd_word;

    assign w_hs       = cmd_valid && r_cmd_ready;
    assign w_has_room = (r_wptr != c_LAST_SLOT);
    assign w_cmd_word = {1'b0, cmd_draw, cmd_x, cmd_y};

    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_we        = 1'b0;
        w_wdata     = w_cmd_word;
        w_ovf_set   = 1'b0;
        case (r_state)
            c_FILL: begin
                if (w_hs) begin
                    if (w_has_room) begin
                        w_we       = 1'b1;
                        w_wptr_nxt = r_wptr + 1'b1;
                        if (cmd_last) begin
                            w_state_nxt = c_SEAL;
                        end
                    end else begin
                        // Last slot is reserved for EOF; the command itself is lost.
                        w_ovf_set = 1'b1;
                        if (cmd_last) begin
                            w_we        = 1'b1;
                            w_wdata     = c_EOF_WORD;
                            w_state_nxt = r_front_valid ? c_WAIT_SWAP : c_SWAP;
                        end
                    end
                end
            end
            c_SEAL: begin
                w_we        = 1'b1;
                w_wdata     = c_EOF_WORD;
                // level cannot represent a completely full bank, so it saturates.
                if (w_has_room) begin
                    w_wptr_nxt = r_wptr + 1'b1;
                end
                w_state_nxt = r_front_valid ? c_WAIT_SWAP : c_SWAP;
            end
            c_WAIT_SWAP: begin
                if (frame_drawn) begin
                    w_state_nxt = c_SWAP;
                end
            end
            c_SWAP: begin
                w_wptr_nxt  = '0;
                w_state_nxt = c_FILL;
            end
            default: begin
                w_state_nxt = c_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_FILL;
            r_wptr        <= '0;
            r_front       <= 1'b0;
            r_front_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_swap_done   <= 1'b0;
            r_cmd_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_cmd_ready <= (w_state_nxt == c_FILL);
            r_swap_done <= (r_state == c_SWAP);
            if (r_state == c_SWAP) begin
                r_front       <= ~r_front;
                r_front_valid <= 1'b1;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Writes only ever target the back bank, so the front bank stays stable.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[{~r_front, r_wptr}] <= w_wdata;
        end
    end

    assign data_out  = r_front_valid ? r_ram[{r_front, addr}] : c_EOF_WORD;
    assign cmd_ready = r_cmd_ready;
    assign swap_done = r_swap_done;
    assign overflow  = r_overflow;
    assign level     = r_wptr;

endmodule
`default_nettype wire
